// File: rtl/keypoint_collector.sv
// Keypoint collector: tracks raster position of NMS survivors and queues them in a FIFO.
// The frame FSM closes a frame after its last pixel once the FIFO has drained.
module keypoint_collector #(
    parameter int unsigned WIDTH           = 640,
    parameter int unsigned HEIGHT          = 480,
    parameter int unsigned FIFO_DEPTH      = 16,
    parameter int unsigned MAX_KP          = 1023,
    parameter bit          DROP_ZERO_DEPTH = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic        i_sof,
    input  logic        i_flag,
    input  logic [7:0]  i_score,
    input  logic [15:0] i_depth,
    output logic        o_kp_valid,
    input  logic        i_kp_ready,
    output logic [9:0]  o_kp_x,
    output logic [9:0]  o_kp_y,
    output logic [7:0]  o_kp_score,
    output logic [15:0] o_kp_depth,
    output logic [10:0] o_kp_count,
    output logic        o_overflow,
    output logic        o_frame_done
);
    localparam int unsigned AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned X_LAST = WIDTH - 1;
    localparam int unsigned Y_LAST = HEIGHT - 1;

    typedef enum logic [1:0] {StIdle, StCollect, StFlush, StDone} state_e;

    state_e        state_q, state_d;
    logic [9:0]    x_q, x_d, y_q, y_d, px_x, px_y;
    logic [10:0]   count_q, count_d, count_base;
    logic          overflow_q, overflow_d, overflow_base;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q;
    logic [43:0]   mem_q [FIFO_DEPTH];
    logic [43:0]   head;
    logic          sof_px, collect, keep, push, pop, last_px, fifo_empty, fifo_full;

    assign fifo_empty = (level_q == '0);
    // Fullness is judged on the pre-pop level, so a same-cycle pop never makes room.
    assign fifo_full  = (level_q == FIFO_DEPTH[AW:0]);

    always_comb begin
        sof_px        = i_valid & i_sof;
        px_x          = sof_px ? '0 : x_q;
        px_y          = sof_px ? '0 : y_q;
        count_base    = sof_px ? '0 : count_q;
        overflow_base = sof_px ? 1'b0 : overflow_q;
        collect       = i_valid & (i_sof | (state_q == StCollect));
        keep          = collect & i_flag & ~(DROP_ZERO_DEPTH & (i_depth == '0));
        push          = keep & (count_base < MAX_KP[10:0]) & ~fifo_full;
        pop           = ~fifo_empty & i_kp_ready;
        count_d       = count_base + {10'd0, push};
        overflow_d    = overflow_base | (keep & ~push);
        last_px       = collect & (px_x == X_LAST[9:0]) & (px_y == Y_LAST[9:0]);

        x_d = x_q;
        y_d = y_q;
        if (i_valid) begin
            if (px_x == X_LAST[9:0]) begin
                x_d = '0;
                y_d = (px_y == Y_LAST[9:0]) ? '0 : px_y + 10'd1;
            end else begin
                x_d = px_x + 10'd1;
                y_d = px_y;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFlush: if (fifo_empty) state_d = StDone;
            StDone:  state_d = StIdle;
            default: ;
        endcase
        if (sof_px) state_d = StCollect;
        if (last_px) state_d = StFlush;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= StIdle;
            x_q        <= '0;
            y_q        <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q    <= level_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_ptr_q] <= {px_x, px_y, i_score, i_depth};
    end

    always_comb begin
        head         = fifo_empty ? '0 : mem_q[rd_ptr_q];
        o_kp_valid   = ~fifo_empty;
        o_kp_x       = head[43:34];
        o_kp_y       = head[33:24];
        o_kp_score   = head[23:16];
        o_kp_depth   = head[15:0];
        o_kp_count   = count_q;
        o_overflow   = overflow_q;
        o_frame_done = (state_q == StDone);
    end
endmodule

// File: tb/tb_keypoint_collector.sv
// Bench for keypoint_collector: two instances (MAX_KP 1023 and 3) checked every cycle
// against a frame-level model with a queue of pending keypoints.
module tb_keypoint_collector;
    localparam int W  = 8;
    localparam int H  = 4;
    localparam int FD = 16;
    localparam int MI = 0, MC = 1, MF = 2, MD = 3;
    localparam int MAXK [2] = '{1023, 3};

    logic        clk, rst, valid, sof, flag, ready;
    logic [7:0]  score;
    logic [15:0] depth;
    logic        kv [2];
    logic [9:0]  kx [2];
    logic [9:0]  ky [2];
    logic [7:0]  ks [2];
    logic [15:0] kd [2];
    logic [10:0] kc [2];
    logic        ko [2];
    logic        kf [2];

    int          n_tests, n_fail;
    int          m_st [2], m_pix [2], m_cnt [2], m_hd [2], m_len [2];
    bit          m_ov [2];
    logic [43:0] m_q [2][64];
    int          done_seen [2], pops [2];

    keypoint_collector #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(FD), .MAX_KP(1023),
                         .DROP_ZERO_DEPTH(1'b1)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_sof(sof), .i_flag(flag),
        .i_score(score), .i_depth(depth), .o_kp_valid(kv[0]), .i_kp_ready(ready),
        .o_kp_x(kx[0]), .o_kp_y(ky[0]), .o_kp_score(ks[0]), .o_kp_depth(kd[0]),
        .o_kp_count(kc[0]), .o_overflow(ko[0]), .o_frame_done(kf[0])
    );

    keypoint_collector #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(FD), .MAX_KP(3),
                         .DROP_ZERO_DEPTH(1'b1)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_sof(sof), .i_flag(flag),
        .i_score(score), .i_depth(depth), .o_kp_valid(kv[1]), .i_kp_ready(ready),
        .o_kp_x(kx[1]), .o_kp_y(ky[1]), .o_kp_score(ks[1]), .o_kp_depth(kd[1]),
        .o_kp_count(kc[1]), .o_overflow(ko[1]), .o_frame_done(kf[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [43:0] obs, input logic [43:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = MI; m_pix[i] = 0; m_cnt[i] = 0; m_ov[i] = 1'b0;
            m_hd[i] = 0; m_len[i] = 0;
        end
    endtask

    task automatic check_inst(input int i);
        logic [43:0] e;
        chk($sformatf("kp_valid%0d", i), kv[i], m_len[i] > 0);
        if (m_len[i] > 0) begin
            e = m_q[i][m_hd[i]];
            chk($sformatf("kp_x%0d", i), kx[i], e[43:34]);
            chk($sformatf("kp_y%0d", i), ky[i], e[33:24]);
            chk($sformatf("kp_score%0d", i), ks[i], e[23:16]);
            chk($sformatf("kp_depth%0d", i), kd[i], e[15:0]);
        end
        chk($sformatf("kp_count%0d", i), kc[i], m_cnt[i]);
        chk($sformatf("overflow%0d", i), ko[i], m_ov[i]);
        chk($sformatf("frame_done%0d", i), kf[i], m_st[i] == MD);
        if (kf[i]) done_seen[i]++;
        if (kv[i] && ready) pops[i]++;
    endtask

    task automatic step_model(input int i);
        int p, px, py, cnt, nst;
        bit ov, coll, kp, push, pop, s;
        s    = valid && sof;
        pop  = (m_len[i] > 0) && ready;
        p    = s ? 0 : m_pix[i];
        px   = p % W;
        py   = p / W;
        coll = valid && (sof || m_st[i] == MC);
        cnt  = s ? 0 : m_cnt[i];
        ov   = s ? 1'b0 : m_ov[i];
        kp   = coll && flag && depth != 0;
        push = kp && cnt < MAXK[i] && m_len[i] < FD;
        if (kp && !push) ov = 1'b1;
        if (push) begin
            m_q[i][(m_hd[i] + m_len[i]) % 64] = {10'(px), 10'(py), score, depth};
            cnt++;
        end
        nst = m_st[i];
        if (m_st[i] == MF && m_len[i] == 0) nst = MD;
        else if (m_st[i] == MD) nst = MI;
        if (s) nst = MC;
        if (coll && p == W * H - 1) nst = MF;
        if (pop) m_hd[i] = (m_hd[i] + 1) % 64;
        m_len[i] = m_len[i] + int'(push) - int'(pop);
        if (valid) m_pix[i] = (p + 1) % (W * H);
        m_st[i] = nst; m_cnt[i] = cnt; m_ov[i] = ov;
    endtask

    task automatic tick();
        for (int i = 0; i < 2; i++) begin
            check_inst(i);
            step_model(i);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pixel(input bit s, input bit f, input logic [15:0] d);
        valid = 1'b1; sof = s; flag = f; depth = d; score = 8'($urandom);
        tick();
        valid = 1'b0; sof = 1'b0; flag = 1'b0;
    endtask

    task automatic drain(input int n);
        ready = 1'b1;
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 2; i++) begin
            done_seen[i] = 0; pops[i] = 0;
        end
    endtask

    task automatic reset_dut();
        valid = 1'b0; sof = 1'b0; flag = 1'b0; rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_valid%0d", i), kv[i], 0);
            chk($sformatf("rst_fields%0d", i), {kx[i], ky[i], ks[i], kd[i]}, 0);
            chk($sformatf("rst_count%0d", i), kc[i], 0);
            chk($sformatf("rst_ovf_done%0d", i), {ko[i], kf[i]}, 0);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        valid = 0; sof = 0; flag = 0; score = 0; depth = 0; ready = 0;
        reset_dut();

        // Single keypoint at pixel 10 -> (2,1)
        clear_stats();
        ready = 1'b1;
        for (int k = 0; k < 32; k++) pixel(k == 0, k == 10, 16'd5);
        drain(6);
        chk("single_pops", pops[0], 1);
        chk("single_done", done_seen[0], 1);

        // Zero depth is discarded silently
        clear_stats();
        for (int k = 0; k < 32; k++) pixel(k == 0, k == 7, 16'd0);
        drain(6);
        chk("zero_count", kc[0], 0);
        chk("zero_ovf", ko[0], 0);
        chk("zero_pops", pops[0], 0);

        // FIFO full with ready low, then drain in raster order
        clear_stats();
        ready = 1'b0;
        for (int k = 0; k < 32; k++) pixel(k == 0, k < 20, 16'(k + 100));
        chk("full_count", kc[0], 16);
        chk("full_ovf", ko[0], 1);
        chk("full_count_lim", kc[1], 3);
        chk("full_ovf_lim", ko[1], 1);
        drain(30);
        chk("full_pops", pops[0], 16);
        chk("full_done", done_seen[0], 1);

        // Count limit with ready high
        clear_stats();
        for (int k = 0; k < 32; k++) pixel(k == 0, k inside {2, 4, 6, 8, 10}, 16'd33);
        drain(6);
        chk("lim_pops", pops[1], 3);
        chk("lim_count", kc[1], 3);
        chk("lim_ovf", ko[1], 1);
        chk("lim_pops_a", pops[0], 5);

        // Reset mid-frame with 4 keypoints queued
        clear_stats();
        ready = 1'b0;
        for (int k = 0; k < 8; k++) pixel(k == 0, k inside {[1:4]}, 16'd7);
        chk("pre_rst_count", kc[0], 4);
        reset_dut();
        ready = 1'b1;
        for (int k = 0; k < 10; k++) pixel(1'b0, 1'b1, 16'd9);
        chk("post_rst_valid", kv[0], 0);
        chk("post_rst_count", kc[0], 0);

        // sof mid-frame at x=5: queued keypoints survive
        clear_stats();
        ready = 1'b0;
        for (int k = 0; k < 13; k++) pixel(k == 0, k inside {3, 7, 9}, 16'd11);
        pixel(1'b1, 1'b1, 16'd9);
        chk("midsof_count", kc[0], 1);
        chk("midsof_count_lim", kc[1], 1);
        for (int k = 1; k < 32; k++) pixel(1'b0, 1'b0, 16'd1);
        drain(12);
        chk("midsof_pops", pops[0], 4);
        chk("midsof_done", done_seen[0], 1);

        // Randomized frames: gaps, random ready, zero depths, rare mid-frame sof
        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < 40; k++) begin
                ready = ($urandom_range(0, 2) != 0);
                if ($urandom_range(0, 3) == 0) begin
                    valid = 1'b0;
                    tick();
                end
                pixel(k == 0 || $urandom_range(0, 49) == 0, $urandom_range(0, 2) == 0,
                      ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom));
            end
            drain(24);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
